// File: rtl/cr_job_sequencer_pkg.sv
// cr_job_sequencer_pkg: shared types and helpers for the correlated-randomness job sequencer.
package cr_job_sequencer_pkg;

   typedef logic [255:0] prng_t;
   typedef logic [127:0] key_t;
   typedef logic [31:0]  cr_cnt_t;
   typedef logic [2:0]   mode_t;
   typedef logic [2:0]   width_t;
   typedef logic [3:0]   cr_lanes_t;

   typedef enum logic [1:0] {IDLE, INIT, FETCH, EMIT} seq_state_t;

   function automatic logic width_legal(width_t w);
      return w inside {3'b000, 3'b001, 3'b011, 3'b111};
   endfunction

   function automatic cr_lanes_t lanes_per_beat(width_t w);
      return (w == 3'b000) ? 4'd8 : (w == 3'b001) ? 4'd4 : (w == 3'b011) ? 4'd2 : 4'd1;
   endfunction

   // Bit 32k marks a 32-bit word that takes the carry from the word below it;
   // 256-bit lanes run on the full-width adder and need no stitching.
   function automatic prng_t make_carry_mask(width_t w);
      prng_t m = '0;
      for (int k = 1; k < 8; k++)
         m[32*k] = (w == 3'b001) ? k[0] : (w == 3'b011) ? (k[1:0] != 2'b00) : 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/cr_job_sequencer.sv
// cr_job_sequencer: runs one CR job at a time, keying the PRNG and forwarding
// one PRNG block per beat tagged with valid-lane count and carry mask.
module cr_job_sequencer
   import cr_job_sequencer_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       job_valid_i,
   output logic       job_ready_o,
   input  mode_t      job_mode_i,
   input  width_t     job_width_i,
   input  cr_cnt_t    job_cnt_i,
   input  key_t       job_key_i,
   input  logic       abort_i,
   output key_t       prng_key_o,
   output logic       prng_init_o,
   output logic       prng_req_o,
   input  logic       prng_valid_i,
   input  prng_t      prng_data_i,
   output logic       cr_valid_o,
   input  logic       cr_ready_i,
   output prng_t      cr_data_o,
   output cr_lanes_t  cr_lanes_o,
   output mode_t      cr_mode_o,
   output prng_t      cr_carry_mask_o,
   output logic       cr_last_o,
   output logic       done_o,
   output logic       err_o
);

   seq_state_t state_q;
   width_t     width_q;
   mode_t      mode_q;
   cr_cnt_t    rem_q, rem_d;
   key_t       key_q;
   prng_t      data_q, mask_q;
   cr_lanes_t  lanes_q, lanes_d, per_beat;
   logic       init_q, req_q, valid_q, done_q, err_q;

   always_comb begin
      per_beat = lanes_per_beat(width_q);
      lanes_d  = (rem_q < {28'd0, per_beat}) ? rem_q[3:0] : per_beat;
      rem_d    = rem_q - {28'd0, lanes_q};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         width_q <= '0;
         mode_q  <= '0;
         rem_q   <= '0;
         key_q   <= '0;
         data_q  <= '0;
         mask_q  <= '0;
         lanes_q <= '0;
         init_q  <= 1'b0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         init_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (abort_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: if (job_valid_i) begin
                  width_q <= job_width_i;
                  mode_q  <= job_mode_i;
                  rem_q   <= job_cnt_i;
                  key_q   <= job_key_i;
                  mask_q  <= make_carry_mask(job_width_i);
                  if (!width_legal(job_width_i)) err_q <= 1'b1;
                  else if (job_cnt_i == '0) done_q <= 1'b1;
                  else begin
                     state_q <= INIT;
                     init_q  <= 1'b1;
                  end
               end
               INIT: begin
                  state_q <= FETCH;
                  req_q   <= 1'b1;
               end
               FETCH: if (req_q && prng_valid_i) begin
                  data_q  <= prng_data_i;
                  lanes_q <= lanes_d;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= EMIT;
               end
               EMIT: if (cr_ready_i) begin
                  valid_q <= 1'b0;
                  rem_q   <= rem_d;
                  if (rem_d == '0) begin
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     req_q   <= 1'b1;
                     state_q <= FETCH;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign job_ready_o     = (state_q == IDLE);
   assign cr_last_o       = valid_q && (rem_q == {28'd0, lanes_q});
   assign prng_key_o      = key_q;
   assign prng_init_o     = init_q;
   assign prng_req_o      = req_q;
   assign cr_valid_o      = valid_q;
   assign cr_data_o       = data_q;
   assign cr_lanes_o      = lanes_q;
   assign cr_mode_o       = mode_q;
   assign cr_carry_mask_o = mask_q;
   assign done_o          = done_q;
   assign err_o           = err_q;

endmodule

// File: tb/tb_cr_job_sequencer.sv
// tb_cr_job_sequencer: directed jobs with a beat scoreboard drained by an
// independent monitor; a PRNG responder supplies blocks with a set latency.
module tb_cr_job_sequencer;
   import cr_job_sequencer_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic      rst, jv, abort, pv, rdy;
   mode_t     jm;
   width_t    jw;
   cr_cnt_t   jc;
   key_t      jk;
   prng_t     pd;
   logic      job_ready_o, prng_init_o, prng_req_o, cr_valid_o, cr_last_o, done_o, err_o;
   key_t      prng_key_o;
   prng_t     cr_data_o, cr_carry_mask_o;
   cr_lanes_t cr_lanes_o;
   mode_t     cr_mode_o;

   cr_job_sequencer dut (
      .clk_i(clk), .rst_i(rst), .job_valid_i(jv), .job_ready_o(job_ready_o),
      .job_mode_i(jm), .job_width_i(jw), .job_cnt_i(jc), .job_key_i(jk),
      .abort_i(abort), .prng_key_o(prng_key_o), .prng_init_o(prng_init_o),
      .prng_req_o(prng_req_o), .prng_valid_i(pv), .prng_data_i(pd),
      .cr_valid_o(cr_valid_o), .cr_ready_i(rdy), .cr_data_o(cr_data_o),
      .cr_lanes_o(cr_lanes_o), .cr_mode_o(cr_mode_o), .cr_carry_mask_o(cr_carry_mask_o),
      .cr_last_o(cr_last_o), .done_o(done_o), .err_o(err_o)
   );

   typedef struct {
      cr_lanes_t lanes;
      logic      last;
      prng_t     mask;
      mode_t     mode;
   } beat_t;

   beat_t eq[$];
   prng_t dq[$];
   int errors = 0, checks = 0;
   int cyc = 0, done_n = 0, err_n = 0, init_n = 0, hs_n = 0, req_n = 0;
   int last_hs_cyc = -100, done_cyc = -100, pdelay = 0;
   prng_t m64;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic prng_t blk(int n);
      prng_t r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = 32'hC0DE_0000 + 32'(n*16 + i);
      return r;
   endfunction

   // PRNG responder: answers a request after pdelay cycles, logging the block
   initial begin
      int dc, bn;
      dc = 0; bn = 0; pv = 1'b0; pd = '0;
      forever begin
         @(negedge clk);
         if (pv) pv = 1'b0;
         else if (prng_req_o) begin
            if (dc >= pdelay) begin
               pv = 1'b1;
               pd = blk(bn);
               dq.push_back(pd);
               bn++;
               dc = 0;
            end else dc++;
         end else dc = 0;
      end
   end

   // Monitor: pulse counters, stall stability and scoreboard drain
   initial begin
      logic      stall;
      prng_t     sdata;
      cr_lanes_t slanes;
      beat_t     b;
      prng_t     d;
      stall = 1'b0; sdata = '0; slanes = '0;
      forever begin
         @(negedge clk);
         if (done_o) begin
            done_n++;
            done_cyc = cyc;
            check("ready_at_done", 256'(job_ready_o), 256'd1);
         end
         if (err_o) err_n++;
         if (prng_init_o) init_n++;
         if (prng_req_o) req_n++;
         if (stall && cr_valid_o) begin
            check("stall_data", cr_data_o, sdata);
            check("stall_lanes", 256'(cr_lanes_o), 256'(slanes));
         end
         if (cr_valid_o && rdy) begin
            hs_n++;
            if (eq.size() == 0 || dq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got lanes %0d with no beat expected", cr_lanes_o);
            end else begin
               b = eq.pop_front();
               d = dq.pop_front();
               check("beat_data", cr_data_o, d);
               check("beat_lanes", 256'(cr_lanes_o), 256'(b.lanes));
               check("beat_last", 256'(cr_last_o), 256'(b.last));
               check("beat_mask", cr_carry_mask_o, b.mask);
               check("beat_mode", 256'(cr_mode_o), 256'(b.mode));
            end
            if (cr_last_o) last_hs_cyc = cyc;
         end
         stall  = cr_valid_o && !rdy;
         sdata  = cr_data_o;
         slanes = cr_lanes_o;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_job(width_t w, cr_cnt_t c, mode_t m, key_t k);
      jv = 1'b1; jw = w; jc = c; jm = m; jk = k;
      tick();
      jv = 1'b0;
   endtask

   task automatic push(cr_lanes_t l, logic last, prng_t m, mode_t md);
      eq.push_back('{l, last, m, md});
   endtask

   task automatic wait_done(int base, int budget, string name);
      int i = 0;
      while (done_n == base && i < budget) begin
         tick();
         i++;
      end
      check(name, 256'(done_n - base), 256'd1);
   endtask

   task automatic wait_hs(int base);
      int i = 0;
      while (hs_n == base && i < 200) begin
         tick();
         i++;
      end
      check("handshake_seen", 256'(hs_n != base), 256'd1);
   endtask

   task automatic wait_valid();
      int i = 0;
      while (!cr_valid_o && i < 200) begin
         tick();
         i++;
      end
      check("beat_presented", 256'(cr_valid_o), 256'd1);
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_ready"}, 256'(job_ready_o), 256'd1);
      check({tag, "_init"},  256'(prng_init_o), 256'd0);
      check({tag, "_req"},   256'(prng_req_o), 256'd0);
      check({tag, "_valid"}, 256'(cr_valid_o), 256'd0);
      check({tag, "_last"},  256'(cr_last_o), 256'd0);
      check({tag, "_done"},  256'(done_o), 256'd0);
      check({tag, "_err"},   256'(err_o), 256'd0);
      check({tag, "_key"},   256'(prng_key_o), 256'd0);
      check({tag, "_data"},  cr_data_o, 256'd0);
      check({tag, "_mask"},  cr_carry_mask_o, 256'd0);
      check({tag, "_lanes"}, 256'(cr_lanes_o), 256'd0);
      check({tag, "_mode"},  256'(cr_mode_o), 256'd0);
   endtask

   initial begin
      int b, e, i0, r, h, i;
      m64 = '0;
      m64[32] = 1'b1; m64[96] = 1'b1; m64[160] = 1'b1; m64[224] = 1'b1;
      rst = 1'b1; jv = 1'b0; abort = 1'b0; rdy = 1'b1;
      jm = '0; jw = '0; jc = '0; jk = '0;
      tick(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // 32-bit lanes, 20 CRs, always ready
      push(4'd8, 1'b0, '0, 3'd2);
      push(4'd8, 1'b0, '0, 3'd2);
      push(4'd4, 1'b1, '0, 3'd2);
      b = done_n; i0 = init_n;
      send_job(3'b000, 32'd20, 3'd2, 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978);
      wait_done(b, 200, "t1_done");
      tick(2);
      check("t1_done_once", 256'(done_n - b), 256'd1);
      check("t1_init_once", 256'(init_n - i0), 256'd1);
      check("t1_done_latency", 256'(done_cyc - last_hs_cyc), 256'd1);
      check("t1_sb_empty", 256'(eq.size()), 256'd0);
      check("t1_key", 256'(prng_key_o), 256'(128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978));

      // 256-bit lanes, stall beat 2 for 5 cycles
      push(4'd1, 1'b0, '0, 3'd5);
      push(4'd1, 1'b0, '0, 3'd5);
      push(4'd1, 1'b1, '0, 3'd5);
      b = done_n;
      h = hs_n;
      send_job(3'b111, 32'd3, 3'd5, 128'hfeed_beef);
      wait_hs(h);
      rdy = 1'b0;
      wait_valid();
      tick(5);
      rdy = 1'b1;
      wait_done(b, 200, "t2_done");
      check("t2_sb_empty", 256'(eq.size()), 256'd0);

      // illegal width, then a zero-count job
      e = err_n; i0 = init_n; b = done_n;
      send_job(3'b101, 32'd5, 3'd0, 128'h33);
      check("t3_ready_after_illegal", 256'(job_ready_o), 256'd1);
      tick(3);
      check("t3_err_pulse", 256'(err_n - e), 256'd1);
      check("t3_no_init", 256'(init_n - i0), 256'd0);
      check("t3_ready_idle", 256'(job_ready_o), 256'd1);
      check("t3_no_done", 256'(done_n - b), 256'd0);
      send_job(3'b011, 32'd0, 3'd1, 128'h44);
      tick(2);
      check("t3_zero_done", 256'(done_n - b), 256'd1);
      check("t3_zero_no_init", 256'(init_n - i0), 256'd0);
      check("t3_zero_no_err", 256'(err_n - e), 256'd1);
      check("t3_zero_key", 256'(prng_key_o), 256'(128'h44));

      // 64-bit lanes with slow PRNG
      pdelay = 7;
      push(4'd4, 1'b0, m64, 3'd4);
      push(4'd4, 1'b0, m64, 3'd4);
      push(4'd2, 1'b1, m64, 3'd4);
      b = done_n; r = req_n;
      send_job(3'b001, 32'd10, 3'd4, 128'h55aa);
      wait_done(b, 400, "t4_done");
      check("t4_req_cycles", 256'(req_n - r), 256'd24);
      check("t4_sb_empty", 256'(eq.size()), 256'd0);
      pdelay = 0;

      // abort in EMIT of beat 2 of 4
      push(4'd8, 1'b0, '0, 3'd1);
      b = done_n; e = err_n; h = hs_n;
      send_job(3'b000, 32'd32, 3'd1, 128'h66);
      wait_hs(h);
      rdy = 1'b0;
      wait_valid();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t5_valid_dropped", 256'(cr_valid_o), 256'd0);
      check("t5_ready_idle", 256'(job_ready_o), 256'd1);
      check("t5_last_low", 256'(cr_last_o), 256'd0);
      tick(3);
      check("t5_no_done", 256'(done_n - b), 256'd0);
      check("t5_no_err", 256'(err_n - e), 256'd0);
      check("t5_sb_empty", 256'(eq.size()), 256'd0);
      dq.delete();
      rdy = 1'b1;
      push(4'd3, 1'b1, '0, 3'd6);
      i0 = init_n;
      send_job(3'b000, 32'd3, 3'd6, 128'h77);
      check("t5_init_pulse", 256'(prng_init_o), 256'd1);
      wait_done(b, 200, "t5_new_done");
      check("t5_new_init_once", 256'(init_n - i0), 256'd1);
      check("t5_new_sb_empty", 256'(eq.size()), 256'd0);

      // reset while fetching
      pdelay = 50;
      send_job(3'b000, 32'd8, 3'd3, 128'h88);
      i = 0;
      while (!prng_req_o && i < 20) begin
         tick();
         i++;
      end
      check("t6_in_fetch", 256'(prng_req_o), 256'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_outputs("t6_midreset");
      tick();
      dq.delete();
      pdelay = 0;

      // abort together with a job offer in IDLE
      b = done_n; e = err_n; i0 = init_n;
      jv = 1'b1; abort = 1'b1; jw = 3'b000; jc = 32'd5; jm = 3'd2; jk = 128'h99;
      tick();
      jv = 1'b0; abort = 1'b0;
      tick(3);
      check("t6_abort_no_init", 256'(init_n - i0), 256'd0);
      check("t6_abort_key", 256'(prng_key_o), 256'd0);
      check("t6_abort_ready", 256'(job_ready_o), 256'd1);
      check("t6_abort_no_done", 256'(done_n - b), 256'd0);
      check("t6_abort_no_err", 256'(err_n - e), 256'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
